down_fifo_drain: RTL
====================

DOWN_FIFO_DRAIN -- requirements
Module: down_fifo_drain

Interface
REQ-001 Parameter DUP_CHECK, default 1, meaning: 1 enables duplicate-word detection, 0 ties dup_o low and holds dup_cnt_o at 0.
REQ-002 Parameter DUP_INIT, default 32'hFFFFFFFF, meaning: reset value of the last-word register used for duplicate compare.
REQ-003 clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 reset_n_i  input  1  asynchronous, active-low reset.
REQ-005 enable_i  input  1  permits new FIFO reads.
REQ-006 flush_i  input  1  synchronous discard of buffered and in-flight words.
REQ-007 clr_cnt_i  input  1  synchronous clear of word_cnt_o, dup_cnt_o and ovf_o.
REQ-008 fifo_dat_i  input  32  FIFO read data, valid when fifo_valid_i=1.
REQ-009 fifo_valid_i  input  1  FIFO read-data valid; asserted exactly one cycle after an accepted fifo_rd_o.
REQ-010 fifo_empty_i  input  1  FIFO empty flag.
REQ-011 fifo_rd_o  output  1  FIFO read enable.
REQ-012 m_dat_o  output  32  output word (head of skid buffer).
REQ-013 m_valid_o  output  1  output word valid.
REQ-014 m_ready_i  input  1  downstream accepts m_dat_o when m_valid_o and m_ready_i are both 1.
REQ-015 dup_o  output  1  one-cycle pulse: accepted word equals the previously accepted word.
REQ-016 dup_cnt_o  output  16  saturating count of duplicate words.
REQ-017 word_cnt_o  output  32  count of output transfers, wraps modulo 2^32.
REQ-018 ovf_o  output  1  sticky: a word arrived while the buffer was full and was dropped.

Function
REQ-019 The block SHALL hold a 2-entry FIFO-ordered skid buffer; occ in {0,1,2}; inflight = fifo_rd_o registered one cycle.
REQ-020 fifo_rd_o SHALL equal enable_i & ~fifo_empty_i & ~flush_i & ((occ + inflight) < 2), combinational from registers and inputs, so a 1-cycle-latency FIFO never overruns the buffer.
REQ-021 Push: fifo_valid_i=1 and no discard pending SHALL write fifo_dat_i to the tail; pop: m_valid_o & m_ready_i SHALL remove the head; simultaneous push and pop SHALL leave occ unchanged and preserve order.
REQ-022 m_valid_o SHALL be (occ != 0); m_dat_o SHALL be the head entry and SHALL be stable while m_valid_o=1 and m_ready_i=0.
REQ-023 Word latency: fifo_rd_o at cycle N -> fifo_valid_i at N+1 -> m_valid_o with that word at N+2 when buffer was empty.
REQ-024 fifo_valid_i with occ=2 and no simultaneous pop SHALL drop the word, set ovf_o=1 and leave buffer contents unchanged.
REQ-025 flush_i=1 SHALL set occ to 0 next cycle and SHALL discard any fifo_valid_i word arriving in the cycle after flush_i (the in-flight read); flush has priority over push and pop; m_valid_o=0 the cycle after flush.
REQ-026 enable_i=0 SHALL stop new reads only; buffered and in-flight words SHALL still be delivered.
REQ-027 Duplicate check (DUP_CHECK=1): every pushed word SHALL be compared with last-pushed register (init DUP_INIT); on equality dup_o=1 for one cycle after the push and dup_cnt_o increments, saturating at 16'hFFFF; last-pushed register updates on every push; dropped or discarded words SHALL NOT be compared or update it.
REQ-028 word_cnt_o SHALL increment by 1 on each output transfer, 32'hFFFFFFFF -> 0.
REQ-029 clr_cnt_i SHALL zero word_cnt_o, dup_cnt_o, ovf_o next cycle, taking priority over same-cycle increments; it SHALL NOT affect buffer or last-pushed register.

Reset
REQ-030 reset_n_i=0 SHALL asynchronously force occ=0, inflight=0, fifo_rd_o=0, m_valid_o=0, m_dat_o=0, dup_o=0, dup_cnt_o=0, word_cnt_o=0, ovf_o=0, last-pushed=DUP_INIT.
REQ-031 Reset asserted mid-transfer SHALL discard all buffered and in-flight words; a fifo_valid_i arriving in the first cycle after reset release SHALL be ignored.
REQ-032 Reset release SHALL be synchronised internally so outputs leave reset on a clock edge.

Verification
REQ-033 Stream 0x1..0x8, m_ready_i=1 -> m_dat_o 0x1..0x8 in order, first at 2 cycles after first fifo_rd_o, word_cnt_o=8, dup_cnt_o=0.
REQ-034 m_ready_i=0 with FIFO non-empty -> occ reaches 2, fifo_rd_o stays 0, m_dat_o held; release -> no loss, ovf_o=0.
REQ-035 Words 0xA, 0xA, 0xA, 0xB -> dup_o pulses twice, dup_cnt_o=2; first word 0xFFFFFFFF after reset -> dup_o=1.
REQ-036 flush_i asserted the cycle after fifo_rd_o with occ=1 -> m_valid_o=0 next cycle, in-flight word never appears, word_cnt_o unchanged.
REQ-037 Force fifo_valid_i with occ=2, m_ready_i=0 -> ovf_o=1 sticky, buffer unchanged; clr_cnt_i -> ovf_o=0, counters 0.
REQ-038 dup_cnt_o preloaded to 16'hFFFF by forced duplicates -> further duplicates keep 16'hFFFF; word_cnt_o at 32'hFFFFFFFF plus one transfer -> 0.

Source files
------------

// File: rtl/down_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module   : down_fifo_drain
// Brief    : Drains a 1-cycle-latency FIFO into a 2-entry skid buffer with
//            duplicate-word detection, transfer counting and overflow flag.
// Revision : 1.0
// ============================================================================
module down_fifo_drain #(
    parameter int          DUP_CHECK = 1,
    parameter logic [31:0] DUP_INIT  = 32'hFFFFFFFF
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        enable_i,
    input  logic        flush_i,
    input  logic        clr_cnt_i,
    input  logic [31:0] fifo_dat_i,
    input  logic        fifo_valid_i,
    input  logic        fifo_empty_i,
    output logic        fifo_rd_o,
    output logic [31:0] m_dat_o,
    output logic        m_valid_o,
    input  logic        m_ready_i,
    output logic        dup_o,
    output logic [15:0] dup_cnt_o,
    output logic [31:0] word_cnt_o,
    output logic        ovf_o
);

    localparam logic [1:0] c_OCC_FULL = 2'd2;

    logic [1:0]  r_rst_sync;
    logic        w_rst_n;
    logic        r_run;
    logic        r_discard;
    logic        r_inflight;
    logic [1:0]  r_occ;
    logic [31:0] r_buf0;
    logic [31:0] r_buf1;
    logic        r_ovf;
    logic [31:0] r_word_cnt;

    logic        w_rd;
    logic        w_pop;
    logic        w_push_raw;
    logic        w_push;
    logic        w_drop;

    // Assert asynchronously, release on a clock edge.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    assign w_rd       = r_run & enable_i & ~fifo_empty_i & ~flush_i &
                        (({1'b0, r_occ} + {2'b00, r_inflight}) < 3'd2);
    assign w_pop      = (r_occ != 2'd0) & m_ready_i & ~flush_i;
    assign w_push_raw = fifo_valid_i & ~r_discard & ~flush_i;
    assign w_push     = w_push_raw & ((r_occ != c_OCC_FULL) | w_pop);
    assign w_drop     = w_push_raw & (r_occ == c_OCC_FULL) & ~w_pop;

    // r_discard drops the read that was in flight across a flush or reset.
    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_run      <= 1'b0;
            r_discard  <= 1'b1;
            r_inflight <= 1'b0;
        end else begin
            r_run      <= 1'b1;
            r_discard  <= flush_i;
            r_inflight <= w_rd;
        end
    end

    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_occ  <= 2'd0;
            r_buf0 <= 32'd0;
            r_buf1 <= 32'd0;
        end else if (flush_i) begin
            r_occ <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_buf0 <= fifo_dat_i;
                    end else begin
                        r_buf1 <= fifo_dat_i;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == c_OCC_FULL) begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= fifo_dat_i;
                    end else begin
                        r_buf0 <= fifo_dat_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ovf      <= 1'b0;
            r_word_cnt <= 32'd0;
        end else if (clr_cnt_i) begin
            r_ovf      <= 1'b0;
            r_word_cnt <= 32'd0;
        end else begin
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (w_pop) begin
                r_word_cnt <= r_word_cnt + 32'd1;
            end
        end
    end

    generate
        if (DUP_CHECK != 0) begin : g_dup
            logic [31:0] r_last;
            logic        r_dup;
            logic [15:0] r_dup_cnt;
            logic        w_is_dup;

            assign w_is_dup = w_push & (fifo_dat_i == r_last);

            always_ff @(posedge clk_i or negedge w_rst_n) begin
                if (!w_rst_n) begin
                    r_last    <= DUP_INIT;
                    r_dup     <= 1'b0;
                    r_dup_cnt <= 16'd0;
                end else begin
                    r_dup <= w_is_dup;
                    if (w_push) begin
                        r_last <= fifo_dat_i;
                    end
                    if (clr_cnt_i) begin
                        r_dup_cnt <= 16'd0;
                    end else if (w_is_dup && (r_dup_cnt != 16'hFFFF)) begin
                        r_dup_cnt <= r_dup_cnt + 16'd1;
                    end
                end
            end

            assign dup_o     = r_dup;
            assign dup_cnt_o = r_dup_cnt;
        end else begin : g_no_dup
            assign dup_o     = 1'b0;
            assign dup_cnt_o = 16'd0;
        end
    endgenerate

    assign fifo_rd_o  = w_rd;
    assign m_dat_o    = r_buf0;
    assign m_valid_o  = (r_occ != 2'd0);
    assign word_cnt_o = r_word_cnt;
    assign ovf_o      = r_ovf;

endmodule
`default_nettype wire
